// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI frame-synchronised register file: FSM encoding
// and command-byte field layout.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_ADDR_W    = 7;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the clk domain (2-flop synchronisers)
// and derives single-cycle sclk rise/fall and ss_n fall strobes.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_n_s,
    output logic ss_fall,
    output logic mosi_s
);

    logic sclk_p0, sclk_p1, sclk_p2;
    logic ss_p0, ss_p1, ss_p2;
    logic mosi_p0, mosi_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            ss_p0   <= 1'b1;
            ss_p1   <= 1'b1;
            ss_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            // p0/p1 are the synchroniser pair; p2 only serves edge detection
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            ss_p0   <= ss_n;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign ss_n_s    = ss_p1;
    assign ss_fall   = ~ss_p1 & ss_p2;
    assign mosi_s    = mosi_p1;

endmodule

// File: rtl/spi_frame_regfile.sv
// SPI mode-0 slave register file; writes land in shadows and go live on frame_sync.
// Optional macro REGFILE_AUTOINC_EN enables burst access with address auto-increment.
module spi_frame_regfile
    import spi_regfile_pkg::*;
#(
    parameter int               NUM_REGS   = 4,
    parameter int               REG_W      = 32,
    parameter logic [REG_W-1:0] RST_VALUE0 = 32'h80FC_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sclk,
    input  logic                      ss_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    input  logic                      frame_sync,
    output logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic                      commit_pulse,
    output logic [7:0]                last_byte
);

    localparam int CNT_W = $clog2(REG_W);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic sclk_rise, sclk_fall, ss_n_s, ss_fall, mosi_s;

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_n_s    (ss_n_s),
        .ss_fall   (ss_fall),
        .mosi_s    (mosi_s)
    );

    state_t                 state, state_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic [REG_W-1:0]       shift_in, shift_out, shift_in_next, rd_word;
    logic [CMD_ADDR_W-1:0]  addr;
    logic                   cmd_wr, word_done, sample, cmd_last, data_last, addr_ok;
    logic [NUM_REGS-1:0]    pending, wr_sel;
    logic [REG_W-1:0]       shadow [NUM_REGS];
    logic [REG_W-1:0]       active [NUM_REGS];

    assign sample        = sclk_rise && !ss_n_s && (state == CMD || state == DATA);
    assign cmd_last      = sample && state == CMD  && bit_cnt == CNT_W'(7);
    assign data_last     = sample && state == DATA && bit_cnt == CNT_W'(REG_W - 1);
    assign shift_in_next = {shift_in[REG_W-2:0], mosi_s};
    assign addr_ok       = 32'(addr) < NUM_REGS;
    assign rd_word       = addr_ok ? active[addr[IDX_W-1:0]] : '0;
    // Out-of-range addresses shift the one-hot select out entirely, dropping the write
    assign wr_sel        = (word_done && cmd_wr) ? (NUM_REGS'(1) << addr) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (ss_fall) state_next = CMD;
            CMD:  if (cmd_last) state_next = DATA;
`ifdef REGFILE_AUTOINC_EN
            DATA: state_next = DATA;
`else
            DATA: if (data_last) state_next = DONE;
`endif
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (ss_n_s) state_next = IDLE;
    end

    // Serial datapath: shift-in on sclk rise, shift-out on sclk fall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            addr      <= '0;
            cmd_wr    <= 1'b0;
            word_done <= 1'b0;
            last_byte <= '0;
        end else begin
            word_done <= data_last;
            if (state == IDLE && ss_fall) bit_cnt <= '0;
            if (sample) begin
                shift_in <= shift_in_next;
                bit_cnt  <= (cmd_last || data_last) ? '0 : bit_cnt + 1'b1;
                if (bit_cnt[2:0] == 3'd7) last_byte <= shift_in_next[7:0];
            end
            if (cmd_last) begin
                addr   <= shift_in_next[CMD_ADDR_W-1:0];
                cmd_wr <= shift_in_next[CMD_WRITE_BIT];
            end
`ifdef REGFILE_AUTOINC_EN
            if (word_done) addr <= (32'(addr) >= NUM_REGS - 1) ? '0 : addr + 1'b1;
`endif
            // bit_cnt == 0 on a fall in DATA marks the start of a word: reload
            if (state == DATA && sclk_fall && !ss_n_s)
                shift_out <= (bit_cnt == '0) ? rd_word : {shift_out[REG_W-2:0], 1'b0};
        end
    end

    // Shadow/active register bank with frame-synchronised commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= (i == 0) ? RST_VALUE0 : '0;
                active[i] <= (i == 0) ? RST_VALUE0 : '0;
            end
            pending      <= '0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= frame_sync && (|pending);
            for (int i = 0; i < NUM_REGS; i++) begin
                if (frame_sync && pending[i]) active[i] <= shadow[i];
                if (wr_sel[i]) begin
                    shadow[i]  <= shift_in;
                    pending[i] <= 1'b1;
                end else if (frame_sync) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*REG_W +: REG_W] = active[g];
    end

    assign miso    = ((state == DATA || state == DONE) && !ss_n_s) ? shift_out[REG_W-1] : 1'b0;
    assign miso_oe = ~ss_n_s;

endmodule

// File: tb/tb_spi_frame_regfile.sv
// Self-checking bench for spi_frame_regfile: directed SPI transactions against a
// shadow/active/pending model, plus literal spot checks.
module tb_spi_frame_regfile;

    localparam int NR = 4;
`ifdef REGFILE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic              frame_sync = 1'b0;
    logic              miso, miso_oe, commit_pulse;
    logic [NR*32-1:0]  regs_flat;
    logic [7:0]        last_byte;

    spi_frame_regfile #(.NUM_REGS(NR), .REG_W(32), .RST_VALUE0(32'h80FC_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk         (sclk),
        .ss_n         (ss_n),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .frame_sync   (frame_sync),
        .regs_flat    (regs_flat),
        .commit_pulse (commit_pulse),
        .last_byte    (last_byte)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Spec-level model: shadow/active/pending plus a scheduled shadow write
    logic [31:0] shadow_m [NR];
    logic [31:0] active_m [NR];
    logic [NR-1:0] pending_m;
    logic cp_exp, oe_exp, ss_prev;
    int   cyc = 0;
    bit   sched_vld = 1'b0;
    int   sched_cyc, sched_addr;
    logic [31:0] sched_data;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                shadow_m[i] = (i == 0) ? 32'h80FC_0000 : 32'h0;
                active_m[i] = shadow_m[i];
            end
            pending_m = '0;
            cp_exp    = 1'b0;
            oe_exp    = 1'b0;
            ss_prev   = 1'b1;
            sched_vld = 1'b0;
        end else begin
            cp_exp = frame_sync && (pending_m != '0);
            if (frame_sync) begin
                for (int i = 0; i < NR; i++)
                    if (pending_m[i]) active_m[i] = shadow_m[i];
                pending_m = '0;
            end
            if (sched_vld && sched_cyc == cyc) begin
                shadow_m[sched_addr]  = sched_data;
                pending_m[sched_addr] = 1'b1;
                sched_vld = 1'b0;
            end
            oe_exp  = !ss_prev;
            ss_prev = ss_n;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            logic [NR*32-1:0] exp_flat;
            for (int i = 0; i < NR; i++) exp_flat[i*32 +: 32] = active_m[i];
            n_checks++;
            if (regs_flat !== exp_flat) begin
                n_fail++;
                $display("FAIL model_regs @%0t: got %h expected %h", $time, regs_flat, exp_flat);
            end
            n_checks++;
            if (commit_pulse !== cp_exp) begin
                n_fail++;
                $display("FAIL model_commit @%0t: got %b expected %b", $time, commit_pulse, cp_exp);
            end
            n_checks++;
            if (miso_oe !== oe_exp) begin
                n_fail++;
                $display("FAIL model_oe @%0t: got %b expected %b", $time, miso_oe, oe_exp);
            end
            if (!oe_exp) begin
                n_checks++;
                if (miso !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_miso_idle @%0t: got %b expected 0", $time, miso);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_fs();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    // One SPI mode-0 transaction: 8-bit command then nd data bits from data[63:..]
    task automatic xfer(input logic [7:0] cmd, input logic [63:0] data, input int nd,
                        input bit fs_last, output logic [31:0] rd);
        logic [71:0] frame;
        int a, w;
        frame = {cmd, data};
        a  = int'(cmd[6:0]);
        rd = '0;
        ss_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < 8 + nd; b++) begin
            sclk = 1'b0;
            mosi = frame[71 - b];
            repeat (4) @(negedge clk);
            if (b >= 8 && b < 40) rd[39 - b] = miso;
            sclk = 1'b1;
            if (b >= 8 && (b - 8) % 32 == 31) begin
                w = (b - 8) / 32;
                if (w == 0 || AUTOINC) begin
                    if (cmd[7] && a < NR) begin
                        sched_vld  = 1'b1;
                        sched_cyc  = cyc + 4;
                        sched_addr = a;
                        sched_data = (w == 0) ? data[63:32] : data[31:0];
                    end
                    a = (a >= NR - 1) ? 0 : a + 1;
                end
            end
            if (fs_last && b == 8 + nd - 1) begin
                repeat (3) @(negedge clk);
                frame_sync = 1'b1;
                @(negedge clk);
                frame_sync = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_reg0", regs_flat[31:0], 32'h80FC_0000);
        check("reset_reg1_3", regs_flat[127:32], 96'h0);
        check("reset_miso", miso, 1'b0);
        check("reset_commit", commit_pulse, 1'b0);

        xfer(8'h81, {32'hDEAD_BEEF, 32'h0}, 32, 1'b0, rd);
        check("wr1_before_fs", regs_flat[63:32], 32'h0);
        check("wr1_last_byte", last_byte, 8'hEF);
        pulse_fs();
        check("wr1_after_fs", regs_flat[63:32], 32'hDEAD_BEEF);
        check("wr1_commit_hi", commit_pulse, 1'b1);
        @(negedge clk);
        check("wr1_commit_lo", commit_pulse, 1'b0);

        xfer(8'h01, 64'h0, 32, 1'b0, rd);
        check("rd1_data", rd, 32'hDEAD_BEEF);
        xfer(8'h05, 64'h0, 32, 1'b0, rd);
        check("rd_oor_data", rd, 32'h0);

        xfer(8'h82, {32'h1234_5678, 32'h0}, 20, 1'b0, rd);
        check("abort_last_byte", last_byte, 8'h34);
        pulse_fs();
        check("abort_commit", commit_pulse, 1'b0);
        check("abort_reg2", regs_flat[95:64], 32'h0);

        xfer(8'h83, {32'hA5A5_A5A5, 32'h0}, 32, 1'b1, rd);
        check("coll_reg3_old", regs_flat[127:96], 32'h0);
        pulse_fs();
        check("coll_reg3_new", regs_flat[127:96], 32'hA5A5_A5A5);
        check("coll_commit", commit_pulse, 1'b1);

        xfer(8'h83, {32'h1, 32'h2}, 64, 1'b0, rd);
        pulse_fs();
        check("burst_reg3", regs_flat[127:96], 32'h1);
        check("burst_reg0", regs_flat[31:0], AUTOINC ? 32'h2 : 32'h80FC_0000);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
